// File: rtl/deemph_decim_if.sv
// Sample-in / audio-out bundle for deemph_decim, plus FIFO status.
// Pure wiring; no latency of its own.
// Backpressure is carried by ready_i toward the block; sample input has none.
interface deemph_decim_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic                    sample_valid_i;
    logic signed [WIDTH-1:0] data_i;
    logic                    ready_i;
    logic                    valid_o;
    logic signed [WIDTH-1:0] data_o;
    logic [FW-1:0]           fill_o;
    logic                    overflow_o;

    // Upstream/downstream side that drives samples and ready.
    modport master (
        output sample_valid_i, data_i, ready_i,
        input  valid_o, data_o, fill_o, overflow_o
    );

    // The de-emphasis/decimation block itself.
    modport slave (
        input  sample_valid_i, data_i, ready_i,
        output valid_o, data_o, fill_o, overflow_o
    );
endinterface

// File: rtl/deemph_decim.sv
// One-pole de-emphasis (pole 1-2^-K) followed by decimate-by-DECIM into a FWFT FIFO.
// Latency: decimated sample visible on data_o one cycle after the DECIM-th strobe.
// Backpressure: ready_i drains the FIFO; a push into a full FIFO with no pop is dropped, overflow_o sticks.
module deemph_decim #(
    parameter int WIDTH = 16,
    parameter int K     = 3,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    deemph_decim_if.slave  bus
);
    localparam int ACCW = WIDTH + K + 1;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW   = $clog2(DEPTH) + 1;
    localparam int CW   = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] data_ext;
    logic signed [ACCW-1:0] acc_step;
    logic signed [ACCW-1:0] y_full;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   cnt_last;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic                   ovf_q, ovf_d;
    logic                   empty, full;
    logic                   push_req, push, pop;
    logic [WIDTH-1:0]       push_dat;

    // Leaky integrator: acc + x - acc/2^K, floor on the shift for both signs.
    always_comb begin
        data_ext = {{(K+1){bus.data_i[WIDTH-1]}}, bus.data_i};
        acc_step = acc_q + data_ext - (acc_q >>> K);
        y_full   = acc_step >>> K;
        push_dat = y_full[WIDTH-1:0];
        cnt_last = (cnt_q == CW'(DECIM - 1));
    end

    // Accumulator and decimation phase only move on a sample strobe.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (bus.sample_valid_i) begin
            acc_d = acc_step;
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        end
    end

    // FIFO control: a pop on the same edge frees a slot, so a push into a full FIFO still lands.
    always_comb begin
        empty    = (fill_q == '0);
        full     = (fill_q == FW'(DEPTH));
        push_req = bus.sample_valid_i && cnt_last;
        pop      = !empty && bus.ready_i;
        push     = push_req && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fill_d   = fill_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
        ovf_d = ovf_q | (push_req & ~push);
    end

    // Filter, decimator, pointers and sticky overflow all clear asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; pointers and fill decide what is visible.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Fall-through head, forced to zero when empty so reset yields data_o = 0.
    always_comb begin
        bus.valid_o    = !empty;
        bus.data_o     = empty ? '0 : mem_q[rd_ptr_q];
        bus.fill_o     = fill_q;
        bus.overflow_o = ovf_q;
    end
endmodule

// File: tb/tb_deemph_decim.sv
module tb_deemph_decim;
    logic clk;
    logic rst;

    deemph_decim_if #(.WIDTH(16), .DEPTH(4)) bus ();

    deemph_decim #(.WIDTH(16), .K(3), .DECIM(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst_first;
        bit sv;
        int d;
        bit rdy;
        int e_vld;
        int e_dat;
        int e_fill;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int last_dut = 0;

    // Reference model state
    logic signed [19:0] m_acc;
    int                 m_cnt;
    int                 q[$];
    int                 m_ovf;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = '0;
        m_cnt = 0;
        q.delete();
        m_ovf = 0;
    endtask

    // Called at posedge+1; returns at next posedge+1.
    task automatic step_x(input bit sv, input int d, input bit rdy,
                          input bit tchk, input int e_vld, input int e_dat, input int e_fill);
        logic signed [15:0] d16;
        logic signed [19:0] dx;
        logic signed [19:0] acc_n;
        logic signed [19:0] yy;
        logic signed [15:0] y16;
        bit pop_m;
        bit full_m;
        d16 = 16'(d);
        bus.sample_valid_i = sv;
        bus.data_i = d16;
        bus.ready_i = rdy;
        @(negedge clk);
        chk("sb_valid", int'(bus.valid_o), (q.size() != 0) ? 1 : 0);
        chk("sb_data",  int'(bus.data_o),  (q.size() != 0) ? q[0] : 0);
        chk("sb_fill",  int'(bus.fill_o),  q.size());
        chk("sb_ovf",   int'(bus.overflow_o), m_ovf);
        if (tchk) begin
            chk("tbl_valid", int'(bus.valid_o), e_vld);
            chk("tbl_data",  int'(bus.data_o),  e_dat);
            chk("tbl_fill",  int'(bus.fill_o),  e_fill);
        end
        if (bus.valid_o && rdy) begin
            n_out++;
            last_dut = int'(bus.data_o);
        end
        if (!rst) begin
            pop_m  = (q.size() != 0) && rdy;
            full_m = (q.size() == 4);
            if (pop_m) void'(q.pop_front());
            if (sv) begin
                dx    = 20'(d16);
                acc_n = m_acc + dx - (m_acc >>> 3);
                m_acc = acc_n;
                if (m_cnt == 3) begin
                    yy  = acc_n >>> 3;
                    y16 = yy[15:0];
                    if (!full_m || pop_m) q.push_back(int'(y16));
                    else m_ovf = 1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit sv, input int d, input bit rdy);
        step_x(sv, d, rdy, 1'b0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        rst = 1'b1;
        bus.sample_valid_i = 1'b0;
        bus.data_i = '0;
        bus.ready_i = 1'b0;
        model_reset();

        // Reset state before any clock edge
        #1;
        chk("rst_valid", int'(bus.valid_o), 0);
        chk("rst_data",  int'(bus.data_o), 0);
        chk("rst_fill",  int'(bus.fill_o), 0);
        chk("rst_ovf",   int'(bus.overflow_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // DC step 1000: fourth strobe pushes 413
        tbl.push_back('{1, 1, 1000, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1000, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1000, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1000, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0,    0, 1, 413, 1});
        tbl.push_back('{0, 0, 0,    1, 1, 413, 1});
        tbl.push_back('{0, 0, 0,    0, 0, 0, 0});
        // Constant -1: floor keeps every output at -1
        tbl.push_back('{1, 1, -1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, -1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, -1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, -1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, -1, 0, 1, -1, 1});
        tbl.push_back('{0, 1, -1, 0, 1, -1, 1});
        tbl.push_back('{0, 1, -1, 0, 1, -1, 1});
        tbl.push_back('{0, 1, -1, 0, 1, -1, 1});
        tbl.push_back('{0, 0, 0,  1, 1, -1, 2});
        tbl.push_back('{0, 0, 0,  1, 1, -1, 1});
        tbl.push_back('{0, 0, 0,  0, 0, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_first) do_reset();
            step_x(tbl[i].sv, tbl[i].d, tbl[i].rdy, 1'b1,
                   tbl[i].e_vld, tbl[i].e_dat, tbl[i].e_fill);
        end

        // DC convergence
        do_reset();
        for (int i = 0; i < 160; i++) step(1'b1, 1000, 1'b1);
        step(1'b0, 0, 1'b1);
        chk("dc_converge", last_dut, 1000);

        // Overflow: ramp 1..20 with no drain
        do_reset();
        for (int i = 1; i <= 20; i++) step(1'b1, i, 1'b0);
        chk("ovf_fill", int'(bus.fill_o), 4);
        chk("ovf_flag", int'(bus.overflow_o), 1);
        n_out = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);
        chk("ovf_drain_count", n_out, 4);
        chk("ovf_drain_fill", int'(bus.fill_o), 0);
        chk("ovf_sticky", int'(bus.overflow_o), 1);

        // Full FIFO with concurrent pop on the push edge
        do_reset();
        for (int i = 1; i <= 19; i++) step(1'b1, 100 * i, 1'b0);
        chk("full_pre_fill", int'(bus.fill_o), 4);
        step(1'b1, 2000, 1'b1);
        chk("full_pop_fill", int'(bus.fill_o), 4);
        chk("full_pop_ovf", int'(bus.overflow_o), 0);
        for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);

        // Back-to-back strobes with ready bursts low
        do_reset();
        n_out = 0;
        for (int i = 0; i < 240; i++) step(1'b1, int'($urandom_range(0, 65535)) - 32768, (i % 12) < 8);
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1);
        chk("b2b_count", n_out, 60);
        chk("b2b_no_ovf", int'(bus.overflow_o), 0);

        // Async reset with 2 queued entries, overflow set, partial decimation
        do_reset();
        for (int i = 1; i <= 20; i++) step(1'b1, i, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b1, 7, 1'b0);
        step(1'b1, 7, 1'b0);
        chk("pre_arst_fill", int'(bus.fill_o), 2);
        chk("pre_arst_ovf", int'(bus.overflow_o), 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", int'(bus.valid_o), 0);
        chk("arst_data",  int'(bus.data_o), 0);
        chk("arst_fill",  int'(bus.fill_o), 0);
        chk("arst_ovf",   int'(bus.overflow_o), 0);
        @(posedge clk);
        #1;
        // Strobes during reset are ignored
        for (int i = 0; i < 3; i++) step(1'b1, 500, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 500, 1'b0);
        chk("post_rst_valid", int'(bus.valid_o), 1);
        chk("post_rst_first", int'(bus.data_o), 207);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/deemph_decim.md
DEEMPH_DECIM -- requirements
Module: deemph_decim

Interface
REQ-001 Parameter WIDTH, default 16, sample width (signed two's complement).
REQ-002 Parameter K, default 3, de-emphasis shift; pole at 1 - 2^-K.
REQ-003 Parameter DECIM, default 4, decimation factor (>= 2).
REQ-004 Parameter DEPTH, default 4, output FIFO depth (power of two).
REQ-005 clk  input  1  the single clock for the block; all state is rising-edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 sample_valid_i  input  1  one-cycle strobe, data_i holds a new FIR output sample.
REQ-008 data_i  input  WIDTH  signed FIR output sample (16.0 format).
REQ-009 ready_i  input  1  downstream accepts data_o this cycle.
REQ-010 valid_o  output  1  data_o holds a valid audio sample.
REQ-011 data_o  output  WIDTH  signed de-emphasised, decimated sample.
REQ-012 fill_o  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-013 overflow_o  output  1  sticky flag, a sample was dropped.

Function
REQ-014 The accumulator acc shall be signed, WIDTH+K+1 bits; y = acc >>> K (arithmetic, floor).
REQ-015 On each sample_valid_i the block shall update acc <= acc + data_i - (acc >>> K), with data_i sign-extended; no other cycle shall change acc.
REQ-016 Decimation counter cnt shall run 0..DECIM-1, increment once per sample_valid_i, and wrap to 0 after DECIM-1.
REQ-017 When sample_valid_i and cnt == DECIM-1, the post-update y (WIDTH LSBs of (acc_next >>> K)) shall be pushed into the FIFO.
REQ-018 The FIFO shall be first-word-fall-through: a push into an empty FIFO at edge t shall drive valid_o=1 and data_o=that sample from t+1.
REQ-019 A pop shall occur on any edge where valid_o && ready_i; data_o shall then present the next entry, or valid_o shall drop to 0 if empty.
REQ-020 A push and a pop on the same edge shall both take effect; fill_o unchanged; this holds when full (no overflow).
REQ-021 A push while full without a simultaneous pop shall be discarded, leave FIFO contents unchanged, and set overflow_o=1.
REQ-022 overflow_o shall stay 1 until reset.
REQ-023 Pointers shall wrap modulo DEPTH; fill_o shall range 0..DEPTH.
REQ-024 data_o shall be stable while valid_o=1 and ready_i=0.
REQ-025 sample_valid_i while rst=1 shall be ignored.

Reset
REQ-026 On rst assertion, immediately and regardless of clk, the block shall clear acc, cnt, FIFO pointers and overflow_o; valid_o=0, data_o=0, fill_o=0.
REQ-027 Reset mid-operation shall discard all queued and partially decimated samples; the first sample after deassertion shall be counted as cnt=0.

Verification
REQ-028 Reset: assert rst between edges with FIFO holding 2 entries -> valid_o, fill_o, overflow_o, data_o all 0 without a clock edge.
REQ-029 DC step, defaults: data_i=1000 on 4 strobes -> acc 1000,1875,2641,3311; one push, data_o=413 one cycle after 4th strobe; continued strobes converge to data_o=1000.
REQ-030 Negative floor: data_i=-1 constant, 8 strobes -> two outputs, each -1.
REQ-031 Overflow: ready_i=0, 20 strobes of ramp 1..20 -> 5 pushes, fill_o=4, overflow_o=1; then ready_i=1 -> 4 samples in push order, 5th absent, fill_o reaches 0, overflow_o stays 1.
REQ-032 Full with concurrent pop: FIFO full, ready_i=1 on the push edge -> oldest sample leaves, new one enters at tail, fill_o=4, overflow_o=0.
REQ-033 Back-to-back strobes every cycle with ready_i=1 -> one output per 4 inputs, no drops, data_o stable under ready_i=0 bursts.
